alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry skid buffer that resolves ALU operands when an entry is accepted.
// Operand forwarding from EX/WB is compiled in only when ALU_ISSUE_FORWARD_EN is defined.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_src_a_sel,
  input  logic            in_src_b_sel,
  input  logic [3:0]      in_alu_control,
  input  logic            fwd_ex_valid,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_in_A,
  output logic [XLEN-1:0] data_in_B,
  output logic [3:0]      alu_control,
  output logic [4:0]      out_rd_addr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] skid_a;
  logic [XLEN-1:0] skid_b;
  logic [3:0]      skid_ctl;
  logic [4:0]      skid_rd;
  logic            skid_valid;

  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            accept;
  logic            drain;

`ifdef ALU_ISSUE_FORWARD_EN
  // EX result is younger than WB, so it wins; x0 is never forwarded.
  always_comb begin
    rs1_value = in_rs1_data;
    if (in_rs1_addr != 5'd0) begin
      if (fwd_ex_valid && (fwd_ex_rd == in_rs1_addr))
        rs1_value = fwd_ex_data;
      else if (fwd_wb_valid && (fwd_wb_rd == in_rs1_addr))
        rs1_value = fwd_wb_data;
    end
  end

  always_comb begin
    rs2_value = in_rs2_data;
    if (in_rs2_addr != 5'd0) begin
      if (fwd_ex_valid && (fwd_ex_rd == in_rs2_addr))
        rs2_value = fwd_ex_data;
      else if (fwd_wb_valid && (fwd_wb_rd == in_rs2_addr))
        rs2_value = fwd_wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
                        in_rs1_addr, in_rs2_addr};
  assign rs1_value = in_rs1_data;
  assign rs2_value = in_rs2_data;
`endif

  // Selects are applied after forwarding, so pc/imm are never overridden.
  assign op_a   = in_src_a_sel ? in_pc  : rs1_value;
  assign op_b   = in_src_b_sel ? in_imm : rs2_value;
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b0;
      data_in_A   <= '0;
      data_in_B   <= '0;
      alu_control <= 4'd0;
      out_rd_addr <= 5'd0;
      skid_a      <= '0;
      skid_b      <= '0;
      skid_ctl    <= 4'd0;
      skid_rd     <= 5'd0;
      skid_valid  <= 1'b0;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            data_in_A   <= op_a;
            data_in_B   <= op_b;
            alu_control <= in_alu_control;
            out_rd_addr <= in_rd_addr;
            out_valid   <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            data_in_A   <= op_a;
            data_in_B   <= op_b;
            alu_control <= in_alu_control;
            out_rd_addr <= in_rd_addr;
          end else if (accept) begin
            skid_a     <= op_a;
            skid_b     <= op_b;
            skid_ctl   <= in_alu_control;
            skid_rd    <= in_rd_addr;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          // Skid entry is older than anything upstream; promote it on drain.
          if (drain) begin
            data_in_A   <= skid_a;
            data_in_B   <= skid_b;
            alu_control <= skid_ctl;
            out_rd_addr <= skid_rd;
            skid_valid  <= 1'b0;
            in_ready    <= 1'b1;
            state       <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand sequences
// for stall/flush/async reset, and random traffic against a queue-based model.
module tb_alu_issue_stage;
  localparam int unsigned XLEN = 32;
`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic            in_src_a_sel, in_src_b_sel;
  logic [3:0]      in_alu_control, alu_control;
  logic            fwd_ex_valid, fwd_wb_valid;
  logic [4:0]      fwd_ex_rd, fwd_wb_rd, out_rd_addr;
  logic [XLEN-1:0] fwd_ex_data, fwd_wb_data, data_in_A, data_in_B;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
    .in_alu_control(in_alu_control),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_in_A(data_in_A), .data_in_B(data_in_B),
    .alu_control(alu_control), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctl;
    logic [4:0]      rd;
  } entry_t;

  typedef struct {
    logic [4:0]      ra1, ra2, rd, exrd, wbrd;
    logic [XLEN-1:0] d1, d2, imm, pc, exd, wbd, ea, eb;
    logic            sa, sb, exv, wbv;
    logic [3:0]      ctl;
  } vec_t;

  int     checks = 0;
  int     failures = 0;
  entry_t q[$];
  bit     mdl_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register value as seen by the issuing instruction, from the forwarding rules.
  function automatic logic [XLEN-1:0] src_val(input logic [4:0] addr, input logic [XLEN-1:0] rf);
    if (!FWD || addr == 5'd0) return rf;
    if (fwd_ex_valid && fwd_ex_rd == addr) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
    return rf;
  endfunction

  function automatic entry_t cur_entry();
    entry_t e;
    e.a   = in_src_a_sel ? in_pc  : src_val(in_rs1_addr, in_rs1_data);
    e.b   = in_src_b_sel ? in_imm : src_val(in_rs2_addr, in_rs2_data);
    e.ctl = in_alu_control;
    e.rd  = in_rd_addr;
    return e;
  endfunction

  // One clock: advance the queue model with the current inputs, then compare.
  task automatic tick();
    entry_t e;
    bit acc, drn;
    acc = in_valid && mdl_rdy;
    drn = (q.size() > 0) && out_ready;
    e   = cur_entry();
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (drn) q.delete(0);
      if (acc) q.push_back(e);
    end
    mdl_rdy = (q.size() < 2);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mdl_rdy));
    if (q.size() > 0) begin
      chk("data_in_A", 64'(data_in_A), 64'(q[0].a));
      chk("data_in_B", 64'(data_in_B), 64'(q[0].b));
      chk("alu_control", 64'(alu_control), 64'(q[0].ctl));
      chk("out_rd_addr", 64'(out_rd_addr), 64'(q[0].rd));
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 1;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_src_a_sel = 0; in_src_b_sel = 0; in_alu_control = 0;
    fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_data = '0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = '0;
  endtask

  task automatic load(input logic [XLEN-1:0] a, input logic [3:0] ctl, input logic [4:0] rd);
    in_valid = 1; in_src_a_sel = 0; in_src_b_sel = 1;
    in_rs1_addr = 5'd1; in_rs1_data = a; in_imm = ~a;
    in_alu_control = ctl; in_rd_addr = rd;
  endtask

  function automatic vec_t mk(input logic [4:0] ra1, input logic [XLEN-1:0] d1,
                              input logic [4:0] ra2, input logic [XLEN-1:0] d2,
                              input logic sa, input logic [XLEN-1:0] pc,
                              input logic sb, input logic [XLEN-1:0] imm,
                              input logic exv, input logic [4:0] exrd, input logic [XLEN-1:0] exd,
                              input logic wbv, input logic [4:0] wbrd, input logic [XLEN-1:0] wbd,
                              input logic [3:0] ctl, input logic [4:0] rd,
                              input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
    vec_t v;
    v.ra1 = ra1; v.d1 = d1; v.ra2 = ra2; v.d2 = d2; v.sa = sa; v.pc = pc;
    v.sb = sb; v.imm = imm; v.exv = exv; v.exrd = exrd; v.exd = exd;
    v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.ctl = ctl; v.rd = rd; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  initial begin
    vec_t vecs[5];
    vecs[0] = mk(5'd1, 32'h5, 5'd2, 32'h3, 0, 32'h0, 0, 32'h0,
                 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 4'h0, 5'd1, 32'h5, 32'h3);
    vecs[1] = mk(5'd7, 32'h11, 5'd3, 32'h22, 0, 32'h0, 0, 32'h0,
                 1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB, 4'h2, 5'd2,
                 FWD ? 32'hAA : 32'h11, 32'h22);
    vecs[2] = mk(5'd0, 32'h33, 5'd9, 32'h44, 0, 32'h0, 0, 32'h0,
                 1, 5'd0, 32'hAA, 1, 5'd9, 32'hCC, 4'h7, 5'd3,
                 32'h33, FWD ? 32'hCC : 32'h44);
    vecs[3] = mk(5'd7, 32'h55, 5'd7, 32'h66, 1, 32'h1000, 1, 32'hFFFF_FFFC,
                 1, 5'd7, 32'hAA, 0, 5'd0, 32'h0, 4'hA, 5'd5, 32'h1000, 32'hFFFF_FFFC);
    vecs[4] = mk(5'd4, 32'h1, 5'd6, 32'h2, 0, 32'h0, 0, 32'h0,
                 1, 5'd5, 32'hAA, 1, 5'd4, 32'hDD, 4'hF, 5'd31,
                 FWD ? 32'hDD : 32'h1, 32'h2);

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data_in_A", 64'(data_in_A), 64'd0);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
    rst = 0;
    tick();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Directed operand vectors, each issued alone into an empty stage.
    for (int i = 0; i < 5; i++) begin
      in_rs1_addr = vecs[i].ra1; in_rs1_data = vecs[i].d1;
      in_rs2_addr = vecs[i].ra2; in_rs2_data = vecs[i].d2;
      in_src_a_sel = vecs[i].sa; in_pc = vecs[i].pc;
      in_src_b_sel = vecs[i].sb; in_imm = vecs[i].imm;
      fwd_ex_valid = vecs[i].exv; fwd_ex_rd = vecs[i].exrd; fwd_ex_data = vecs[i].exd;
      fwd_wb_valid = vecs[i].wbv; fwd_wb_rd = vecs[i].wbrd; fwd_wb_data = vecs[i].wbd;
      in_alu_control = vecs[i].ctl; in_rd_addr = vecs[i].rd;
      in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_A", i), 64'(data_in_A), 64'(vecs[i].ea));
      chk($sformatf("vec%0d_B", i), 64'(data_in_B), 64'(vecs[i].eb));
      chk($sformatf("vec%0d_ctl", i), 64'(alu_control), 64'(vecs[i].ctl));
      tick();
    end
    idle_inputs();

    // Stall: fill both entries, hold a third, then drain in order.
    out_ready = 0;
    load(32'h101, 4'h1, 5'd11); tick();
    load(32'h202, 4'h2, 5'd12); tick();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_A", 64'(data_in_A), 64'h101);
    load(32'h303, 4'h3, 5'd13); tick();
    chk("stall_hold_A", 64'(data_in_A), 64'h101);
    out_ready = 1; tick();
    chk("drain1_A", 64'(data_in_A), 64'h202);
    chk("drain1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 0;
    chk("drain2_A", 64'(data_in_A), 64'h303);
    tick(); tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a simultaneous offer.
    out_ready = 0;
    load(32'h404, 4'h4, 5'd14); tick();
    load(32'h505, 4'h5, 5'd15); tick();
    chk("pre_flush_full", 64'(in_ready), 64'd0);
    flush = 1; load(32'h606, 4'h6, 5'd16); tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 0; in_valid = 0; out_ready = 1; tick();
    chk("flush_not_captured", 64'(out_valid), 64'd0);

    // Async reset mid-stall must clear outputs without a clock edge.
    out_ready = 0;
    load(32'h707, 4'h7, 5'd17); tick();
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_A", 64'(data_in_A), 64'd0);
    chk("async_rst_rd", 64'(out_rd_addr), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 0;
    q.delete(); mdl_rdy = 0;
    out_ready = 1;
    tick();

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom); in_alu_control = 4'($urandom);
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom; in_pc = $urandom;
      in_src_a_sel = 1'($urandom); in_src_b_sel = 1'($urandom);
      fwd_ex_valid = 1'($urandom); fwd_ex_rd = 5'($urandom_range(0, 3)); fwd_ex_data = $urandom;
      fwd_wb_valid = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 3)); fwd_wb_data = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
